// File: rtl/myip_burst_pkg.sv
`default_nettype none
// ============================================================================
// Module   : myip_burst_pkg
// Purpose  : Shared constants, AXI tie-off values and FSM state encoding for
//            the AXI4 burst test engine.
// Revision : 1.0 - initial release
// ============================================================================
package myip_burst_pkg;

    localparam int BURST_LEN   = 8;
    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 32;
    localparam int BEAT_W      = 3;
    localparam int BURST_CNT_W = 4;

    // AXI fields that are constant for every transaction this engine issues;
    // the wrapper drives them onto the bus directly.
    localparam logic [7:0]        AXLEN        = 8'(BURST_LEN - 1);
    localparam logic [2:0]        AXSIZE       = 3'b010;
    localparam logic [1:0]        AXBURST_INCR = 2'b01;
    localparam logic              AXID         = 1'b0;
    localparam logic [3:0]        WSTRB_ALL    = 4'hF;
    localparam logic [1:0]        RESP_OKAY    = 2'b00;

    // Byte distance between consecutive burst start addresses.
    localparam logic [ADDR_W-1:0] BURST_STRIDE = ADDR_W'(BURST_LEN * DATA_W / 8);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/myip_burst_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : myip_burst_pattern_gen
// Purpose  : Test data pattern: beat k of burst n carries n*8 + k + 1.
//            Shared by the write data path and the read compare path.
// Revision : 1.0 - initial release
// ============================================================================
module myip_burst_pattern_gen
    import myip_burst_pkg::*;
(
    input  logic [BURST_CNT_W-1:0] i_burst,
    input  logic [BEAT_W-1:0]      i_beat,
    output logic [DATA_W-1:0]      o_data
);

    // {burst, beat} is exactly n*8 + k because a burst is 8 beats long.
    assign o_data = DATA_W'({i_burst, i_beat}) + DATA_W'(1);

endmodule
`default_nettype wire

// File: rtl/myip_m_axi_burst_engine.sv
`default_nettype none
// ============================================================================
// Module   : myip_m_axi_burst_engine
// Purpose  : AXI4 master self-test: writes C_NUM_BURSTS 8-beat INCR bursts of
//            a known pattern, reads them back, compares, and reports
//            TXN_DONE / sticky ERROR.
// Revision : 1.0 - initial release
// ============================================================================
module myip_m_axi_burst_engine
    import myip_burst_pkg::*;
#(
    parameter logic [31:0] C_TARGET_BASE_ADDR = 32'h4000_0000,
    parameter int          C_NUM_BURSTS       = 4
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        INIT_AXI_TXN,
    output logic        TXN_DONE,
    output logic        ERROR,
    output logic [31:0] M_AXI_AWADDR,
    output logic [7:0]  M_AXI_AWLEN,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [31:0] M_AXI_WDATA,
    output logic        M_AXI_WLAST,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,
    input  logic [1:0]  M_AXI_BRESP,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,
    output logic [31:0] M_AXI_ARADDR,
    output logic [7:0]  M_AXI_ARLEN,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RLAST,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY
);

    localparam logic [BURST_CNT_W-1:0] c_last_burst = BURST_CNT_W'(C_NUM_BURSTS - 1);
    localparam logic [BEAT_W-1:0]      c_last_beat  = BEAT_W'(BURST_LEN - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_init_q;
    logic [BURST_CNT_W-1:0] r_burst;
    logic [BEAT_W-1:0]      r_beat;
    logic [31:0]            r_awaddr;
    logic [31:0]            r_araddr;
    logic                   r_awvalid;
    logic                   r_wvalid;
    logic                   r_arvalid;
    logic                   r_done;
    logic                   r_error;
    logic [DATA_W-1:0]      w_pattern;
    logic                   w_start;
    logic                   w_enter_write;
    logic                   w_b_hs;
    logic                   w_r_hs;
    logic                   w_last_burst;
    logic                   w_last_beat;
    logic                   w_r_bad;

    // Write and read passes never overlap, so one counter pair and one
    // pattern generator serve both the W data and the R compare.
    myip_burst_pattern_gen u_pattern_gen (
        .i_burst (r_burst),
        .i_beat  (r_beat),
        .o_data  (w_pattern)
    );

    assign w_start       = INIT_AXI_TXN & ~r_init_q;
    assign w_enter_write = w_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_b_hs        = M_AXI_BVALID && M_AXI_BREADY;
    assign w_r_hs        = M_AXI_RVALID && M_AXI_RREADY;
    assign w_last_burst  = (r_burst == c_last_burst);
    assign w_last_beat   = (r_beat == c_last_beat);
    assign w_r_bad       = (M_AXI_RRESP != RESP_OKAY) || (M_AXI_RDATA != w_pattern) ||
                           (M_AXI_RLAST != w_last_beat);

    assign M_AXI_AWADDR  = r_awaddr;
    assign M_AXI_AWLEN   = AXLEN;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = w_pattern;
    assign M_AXI_WLAST   = w_last_beat;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = (r_state == ST_WRITE);
    assign M_AXI_ARADDR  = r_araddr;
    assign M_AXI_ARLEN   = AXLEN;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = (r_state == ST_READ);
    assign TXN_DONE      = r_done;
    assign ERROR         = r_error;

    // Start-edge detector; resets high so a request held through reset is not an edge.
    always_ff @(posedge ACLK) begin
        if (ARESET) r_init_q <= 1'b1;
        else        r_init_q <= INIT_AXI_TXN;
    end

    // State register.
    always_ff @(posedge ACLK) begin
        if (ARESET) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state: passes end on the last B handshake and the last R beat.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (w_start) w_state_nxt = ST_WRITE;
            ST_WRITE: if (w_b_hs && w_last_burst) w_state_nxt = ST_READ;
            ST_READ:  if (w_r_hs && w_last_beat && w_last_burst) w_state_nxt = ST_DONE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Channel datapath: VALID flags, addresses, counters, done and sticky error.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_burst   <= '0;
            r_beat    <= '0;
            r_awaddr  <= '0;
            r_araddr  <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_arvalid <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else if (w_enter_write) begin
            r_burst   <= '0;
            r_beat    <= '0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_awaddr  <= C_TARGET_BASE_ADDR;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
        end else if (r_state == ST_WRITE) begin
            if (r_awvalid && M_AXI_AWREADY) r_awvalid <= 1'b0;
            if (r_wvalid && M_AXI_WREADY) begin
                r_beat <= r_beat + BEAT_W'(1);
                if (w_last_beat) r_wvalid <= 1'b0;
            end
            if (w_b_hs) begin
                // A response before address and data are both out is a protocol error.
                if ((M_AXI_BRESP != RESP_OKAY) || r_awvalid || r_wvalid) r_error <= 1'b1;
                r_beat <= '0;
                if (w_last_burst) begin
                    r_burst   <= '0;
                    r_araddr  <= C_TARGET_BASE_ADDR;
                    r_arvalid <= 1'b1;
                end else begin
                    r_burst   <= r_burst + BURST_CNT_W'(1);
                    r_awaddr  <= r_awaddr + BURST_STRIDE;
                    r_awvalid <= 1'b1;
                    r_wvalid  <= 1'b1;
                end
            end
        end else if (r_state == ST_READ) begin
            if (r_arvalid && M_AXI_ARREADY) r_arvalid <= 1'b0;
            if (w_r_hs) begin
                if (w_r_bad || r_arvalid) r_error <= 1'b1;
                r_beat <= r_beat + BEAT_W'(1);
                if (w_last_beat) begin
                    if (w_last_burst) begin
                        r_done <= 1'b1;
                    end else begin
                        r_burst   <= r_burst + BURST_CNT_W'(1);
                        r_araddr  <= r_araddr + BURST_STRIDE;
                        r_arvalid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
